// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the M stage
// and the debug/loader port, with bounded debug starvation.
module dmem_arbiter #(
  parameter int MAX_CORE_BURST = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_CORE,
    BUSY_DBG,
    DONE_CORE
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_CORE_BURST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_be;
  logic [31:0]         r_core_rdata;
  logic [31:0]         r_dbg_rdata;
  logic                r_dbg_rvalid;

  logic                w_core_win;
  logic                w_gnt_core;
  logic                w_gnt_dbg;
  logic                w_ack_core;
  logic                w_ack_dbg;
  logic                w_burst_ok;

  assign w_burst_ok = (r_cnt < LP_MAX);
  assign w_core_win = core_req & (~dbg_req | w_burst_ok);
  assign w_ack_core = (r_state == BUSY_CORE) & mem_ack;
  assign w_ack_dbg  = (r_state == BUSY_DBG) & mem_ack;

  // Next-state selection and grant decode
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_core  = 1'b0;
    w_gnt_dbg   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_core_win) begin
          w_gnt_core  = 1'b1;
          w_state_nxt = BUSY_CORE;
        end else if (dbg_req) begin
          w_gnt_dbg   = 1'b1;
          w_state_nxt = BUSY_DBG;
        end
      end
      BUSY_CORE: begin
        if (mem_ack) w_state_nxt = DONE_CORE;
      end
      BUSY_DBG: begin
        if (mem_ack) w_state_nxt = IDLE;
      end
      DONE_CORE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Core burst counter bounding debug starvation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_gnt_dbg) begin
      r_cnt <= 4'd0;
    end else if ((r_state == IDLE) & ~dbg_req) begin
      r_cnt <= 4'd0;
    end else if (w_gnt_core & dbg_req & w_burst_ok) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Memory request: raised on a grant, dropped after the ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req <= 1'b0;
    end else if (w_gnt_core | w_gnt_dbg) begin
      r_mem_req <= 1'b1;
    end else if (w_ack_core | w_ack_dbg) begin
      r_mem_req <= 1'b0;
    end
  end

  // Access fields: captured at grant, held for the whole access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
    end else if (w_gnt_core) begin
      r_mem_we    <= core_we;
      r_mem_addr  <= core_addr;
      r_mem_wdata <= core_wdata;
      r_mem_be    <= core_be;
    end else if (w_gnt_dbg) begin
      r_mem_we    <= dbg_we;
      r_mem_addr  <= dbg_addr;
      r_mem_wdata <= dbg_wdata;
      r_mem_be    <= 4'hF;
    end
  end

  // Read data capture and debug completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_rdata <= 32'd0;
      r_dbg_rdata  <= 32'd0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_dbg_rvalid <= w_ack_dbg;
      if (w_ack_core) r_core_rdata <= mem_rdata;
      if (w_ack_dbg)  r_dbg_rdata  <= mem_rdata;
    end
  end

  assign core_stall = core_req & (r_state != DONE_CORE);
  assign core_rdata = r_core_rdata;
  // no grant is reported while reset holds the arbiter
  assign dbg_gnt    = w_gnt_dbg & rst;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus scoreboard for dmem_arbiter,
// with a behavioural memory that acks after a set delay.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dmem_arbiter #(
    .MAX_CORE_BURST(4),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_be(core_be),
    .core_stall(core_stall),
    .core_rdata(core_rdata),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_dly;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } iss_t;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } rd_t;

  iss_t iss_q[$];
  rd_t  crd_q[$];
  rd_t  drd_q[$];

  logic [31:0] mem [logic [31:0]];

  int n_chk = 0;
  int n_err = 0;
  int ack_dly = 0;
  int reqcyc = 0;
  int rv_cnt = 0;

  vec_t tv[8];
  vec_t v;

  task automatic check(input string nm,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  task automatic mem_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] be);
    logic [31:0] t;
    t = mem_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) t[8*b +: 8] = d[8*b +: 8];
    mem[a] = t;
  endtask

  task automatic wait_stall(output int n);
    bit done;
    done = 0;
    n = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (core_stall) n++;
      else done = 1;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL stall_timeout: got stall after %0d cycles", n);
    end
  endtask

  task automatic wait_rvalid(output int n);
    bit done;
    done = 0;
    n = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      n++;
      if (dbg_rvalid) done = 1;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL rvalid_timeout: got none in %0d cycles", n);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory model: acks after ack_dly extra cycles of mem_req
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= ack_dly) begin
          mem_ack = 1;
          mem_rdata = mem_rd(mem_addr);
          if (mem_we) mem_wr(mem_addr, mem_wdata, mem_be);
          wcnt = 0;
        end else begin
          mem_ack = 0;
          wcnt++;
        end
      end else begin
        mem_ack = 0;
        wcnt = 0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    bit   prev_req;
    bit   has_cur;
    iss_t cur;
    rd_t  r;
    prev_req = 0;
    has_cur = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!prev_req) begin
          if (iss_q.size() == 0) begin
            n_chk++;
            n_err++;
            has_cur = 0;
            $display("FAIL issue: got unexpected mem_req addr %0h", mem_addr);
          end else begin
            cur = iss_q.pop_front();
            has_cur = 1;
          end
        end
        if (has_cur)
          check("mem_fields",
            96'({mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'h0}),
            96'({cur.we, cur.addr, cur.be, cur.we ? cur.wdata : 32'h0}));
        reqcyc++;
      end
      if (core_req && !core_stall) begin
        if (crd_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL core_done: got unexpected completion");
        end else begin
          r = crd_q.pop_front();
          if (r.chk) check("core_rdata", 96'(core_rdata), 96'(r.data));
        end
      end
      if (dbg_rvalid) begin
        rv_cnt++;
        if (drd_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL dbg_done: got unexpected dbg_rvalid");
        end else begin
          r = drd_q.pop_front();
          if (r.chk) check("dbg_rdata", 96'(dbg_rdata), 96'(r.data));
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    int rq0;
    int rv0;
    int rv_at;
    bit done;

    tv[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        4'hF, 0, 32'hDEADBEEF, 2};
    tv[1] = '{1'b0, 1'b1, 32'h64,  32'h7,        4'hF, 2, 32'h0,        4};
    tv[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 1, 32'h12345678, 3};
    tv[3] = '{1'b0, 1'b0, 32'h80,  32'h0,        4'h3, 1, 32'hCAFEF00D, 3};
    tv[4] = '{1'b1, 1'b1, 32'h104, 32'hA5A55A5A, 4'hF, 0, 32'h0,        2};
    tv[5] = '{1'b1, 1'b0, 32'h104, 32'h0,        4'hF, 0, 32'hA5A55A5A, 2};
    tv[6] = '{1'b0, 1'b1, 32'h108, 32'h11223344, 4'h5, 3, 32'h0,        5};
    tv[7] = '{1'b0, 1'b0, 32'h108, 32'h0,        4'hF, 0, 32'hFF22FF44, 2};

    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h100] = 32'h12345678;
    mem[32'h80]  = 32'hCAFEF00D;
    mem[32'h108] = 32'hFFFFFFFF;

    rst = 0;
    core_req = 0;
    core_we = 0;
    core_addr = 0;
    core_wdata = 0;
    core_be = 0;
    dbg_req = 0;
    dbg_we = 0;
    dbg_addr = 0;
    dbg_wdata = 0;

    repeat (2) @(negedge clk);
    check("rst_mem_req", 96'(mem_req), 96'(0));
    check("rst_dbg_gnt", 96'(dbg_gnt), 96'(0));
    check("rst_dbg_rvalid", 96'(dbg_rvalid), 96'(0));
    check("rst_core_rdata", 96'(core_rdata), 96'(0));
    check("rst_dbg_rdata", 96'(dbg_rdata), 96'(0));
    check("rst_mem_fields", 96'({mem_we, mem_addr, mem_be}), 96'(0));
    check("rst_core_stall", 96'(core_stall), 96'(0));
    @(posedge clk);
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("idle_no_req", 96'(mem_req), 96'(0));

    for (int i = 0; i < 8; i++) begin
      v = tv[i];
      ack_dly = v.ack_dly;
      rq0 = reqcyc;
      iss_q.push_back('{v.we, v.addr, v.wdata, v.be});
      if (v.dbg) drd_q.push_back('{!v.we, v.rdata});
      else crd_q.push_back('{!v.we, v.rdata});
      @(posedge clk);
      #1;
      if (!v.dbg) begin
        core_req = 1;
        core_we = v.we;
        core_addr = v.addr;
        core_wdata = v.wdata;
        core_be = v.be;
        wait_stall(n);
        check($sformatf("v%0d_stall", i), 96'(n), 96'(v.lat));
        @(posedge clk);
        #1 core_req = 0;
      end else begin
        dbg_req = 1;
        dbg_we = v.we;
        dbg_addr = v.addr;
        dbg_wdata = v.wdata;
        @(negedge clk);
        check($sformatf("v%0d_gnt", i), 96'(dbg_gnt), 96'(1));
        @(posedge clk);
        #1;
        dbg_req = 0;
        dbg_we = ~v.we;
        dbg_addr = ~v.addr;
        dbg_wdata = ~v.wdata;
        wait_rvalid(n);
        check($sformatf("v%0d_rv_lat", i), 96'(n), 96'(v.lat));
        @(negedge clk);
        check($sformatf("v%0d_rv_pulse", i), 96'(dbg_rvalid), 96'(0));
      end
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_reqcyc", i), 96'(reqcyc - rq0),
            96'(v.ack_dly + 1));
    end

    // both sides requesting continuously: 4 core grants, then debug
    ack_dly = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        iss_q.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
        crd_q.push_back('{1'b1, 32'hDEADBEEF});
      end
      iss_q.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
      drd_q.push_back('{1'b1, 32'h12345678});
    end
    @(posedge clk);
    #1;
    core_req = 1;
    core_we = 0;
    core_addr = 32'h40;
    core_wdata = 0;
    core_be = 4'hF;
    dbg_req = 1;
    dbg_we = 0;
    dbg_addr = 32'h100;
    dbg_wdata = 0;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      check($sformatf("burst_gnt_c%0d", c), 96'(dbg_gnt),
            96'((c % 14) == 12));
    end
    @(posedge clk);
    #1;
    core_req = 0;
    dbg_req = 0;
    repeat (3) @(negedge clk);

    // reset in the middle of a core access with the ack withheld
    ack_dly = 1000;
    rv0 = rv_cnt;
    iss_q.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
    iss_q.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
    crd_q.push_back('{1'b1, 32'hCAFEF00D});
    @(posedge clk);
    #1;
    core_req = 1;
    core_we = 0;
    core_addr = 32'h80;
    core_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_busy_req", 96'(mem_req), 96'(1));
    #2 rst = 0;
    #1;
    check("rstmid_req_drop", 96'(mem_req), 96'(0));
    ack_dly = 0;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("rstmid_idle_req", 96'(mem_req), 96'(0));
    n0 = core_stall ? 1 : 0;
    wait_stall(n);
    check("rstmid_reissue_stall", 96'(n0 + n), 96'(2));
    check("rstmid_no_rvalid", 96'(rv_cnt - rv0), 96'(0));
    @(posedge clk);
    #1 core_req = 0;
    repeat (2) @(negedge clk);

    // core request arriving while a debug write is in flight
    ack_dly = 1;
    iss_q.push_back('{1'b1, 32'h200, 32'h0BADCAFE, 4'hF});
    iss_q.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    drd_q.push_back('{1'b0, 32'h0});
    crd_q.push_back('{1'b1, 32'h0BADCAFE});
    @(posedge clk);
    #1;
    dbg_req = 1;
    dbg_we = 1;
    dbg_addr = 32'h200;
    dbg_wdata = 32'h0BADCAFE;
    @(negedge clk);
    check("inflight_gnt", 96'(dbg_gnt), 96'(1));
    @(posedge clk);
    #1;
    dbg_req = 0;
    dbg_addr = 32'hFFFFFFF0;
    dbg_wdata = 0;
    core_req = 1;
    core_we = 0;
    core_addr = 32'h200;
    core_wdata = 0;
    core_be = 4'hF;
    n = 0;
    rv_at = -1;
    done = 0;
    for (int c = 1; c < 100 && !done; c++) begin
      @(negedge clk);
      if (dbg_rvalid) begin
        rv_at = c;
        check("inflight_req_at_rv", 96'(mem_req), 96'(0));
      end
      if (core_stall) n++;
      else done = 1;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL inflight_timeout: got stall stuck expected release");
    end
    check("inflight_stall", 96'(n), 96'(5));
    check("inflight_rv_at", 96'(rv_at), 96'(3));
    @(posedge clk);
    #1 core_req = 0;
    repeat (3) @(negedge clk);

    check("iss_q_empty", 96'(iss_q.size()), 96'(0));
    check("crd_q_empty", 96'(crd_q.size()), 96'(0));
    check("drd_q_empty", 96'(drd_q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port between the pipeline's M stage and a debug/loader port.
- Debug/loader traffic covers program load and memory inspection.
- Drives a registered request/acknowledge interface to the data memory, which may take one or more cycles to acknowledge.
- Stalls the core pipeline until its access completes.
- Bounds debug starvation with a burst counter.

Parameters:
- MAX_CORE_BURST, 4: maximum consecutive core grants while dbg_req is pending before debug is forced; legal range 1..15.
- ADDR_W, 32: address width of all address ports.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- core_req  in  1  M-stage access request (mem_read | mem_write)
- core_we  in  1  core write enable
- core_addr  in  ADDR_W  core address (data_addr_m)
- core_wdata  in  32  core store data (write_data_m)
- core_be  in  4  core byte enables
- core_stall  out  1  freeze pipeline; high while core access is outstanding
- core_rdata  out  32  core load data, valid when core_req & ~core_stall
- dbg_req  in  1  debug access request
- dbg_we  in  1  debug write enable (always full word)
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  one-cycle pulse: debug request accepted
- dbg_rvalid  out  1  one-cycle pulse: debug access complete
- dbg_rdata  out  32  debug read data, valid with dbg_rvalid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  memory completes the current access this cycle
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (rst low, async): state IDLE, burst count 0, all registered outputs 0, so mem_req, dbg_gnt, dbg_rvalid, core_rdata and dbg_rdata are 0. Reset mid-access drops mem_req immediately and abandons the access; no completion pulse follows.
- States:
  - IDLE: no access outstanding.
  - BUSY_CORE / BUSY_DBG: access outstanding for the named requester.
  - DONE_CORE: core completion cycle.
- IDLE selection:
  - Core wins if core_req and (~dbg_req or count < MAX_CORE_BURST).
  - Otherwise debug wins if dbg_req.
  - On a grant, register the winner's we/addr/wdata/be into mem_*. Debug uses be=4'hF.
  - Set mem_req=1 next cycle and go to BUSY_CORE / BUSY_DBG.
- dbg_gnt pulses in the IDLE cycle that selects debug. After dbg_gnt, the debug side may drop or change its inputs.
- BUSY_x: hold all mem_* stable while mem_req=1 and ~mem_ack. When mem_ack is seen, clear mem_req at the next edge and latch mem_rdata.
  - Core: latch into core_rdata, go to DONE_CORE.
  - Debug: latch into dbg_rdata, pulse dbg_rvalid next cycle, go to IDLE.
  - Writes also latch (value don't-care) and complete the same way.
- mem_ack outside BUSY_x is ignored.
- Core stall rule:
  - core_stall = core_req & (state != DONE_CORE), combinational.
  - In DONE_CORE the pipeline advances with core_rdata valid. The still-asserted core_req is not re-arbitrated; the state returns to IDLE.
- Core latency: request seen in cycle 0, mem_req high in cycle 1, ack earliest in cycle 1, stall low in cycle 2. Minimum 2 stall cycles per access.
- Debug latency: minimum 3 cycles from dbg_req to dbg_rvalid.
- Burst counter:
  - Increments on a core grant while dbg_req=1, saturating at MAX_CORE_BURST.
  - Clears on a debug grant, or in any IDLE cycle with dbg_req=0.
- Back-to-back rules:
  - Debug may be re-granted from IDLE the cycle after dbg_rvalid.
  - A core request arriving while debug is BUSY stalls until debug completes plus the normal core latency.
- With no requests, mem_req stays 0 and the state stays IDLE.

Test Plan:
- Core load, mem_ack on first cycle of mem_req, addr 0x0000_0040, mem_rdata 0xDEAD_BEEF -> mem_req high exactly 1 cycle with mem_addr 0x40 and mem_we 0; core_stall high 2 cycles; core_rdata=0xDEADBEEF when stall drops.
- Core store addr 0x64 data 0x0000_0007 be 4'hF, mem_ack delayed 3 cycles -> mem_* stable for 3 cycles; core_stall high 4 cycles; no duplicate mem_req after DONE_CORE.
- Debug read addr 0x100, ack after 2 cycles, data 0x1234_5678 -> dbg_gnt pulse at cycle 0; dbg_rvalid pulse 1 cycle after ack; dbg_rdata=0x12345678.
- Core and debug continuously requesting, MAX_CORE_BURST=4, every access acked on its first mem_req cycle -> 4 core grants, 1 debug grant, repeating; counter clears after the debug grant.
- rst pulsed low during BUSY_CORE with mem_ack withheld -> mem_req low immediately; after release the state is IDLE, there is no dbg_rvalid, and the held core_req is re-issued from scratch.
- Debug write in flight when core_req rises -> core_stall held through the debug completion plus 2 cycles; core access starts only after the state returns to IDLE.
